// File: rtl/branch_resolver_pkg.sv
// Shared constants for the branch resolver.
// Data width, zero value, booleans, queue depth.
package branch_resolver_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int BQ_DEPTH   = 4;

  localparam logic [DATA_WIDTH-1:0] ZERO_DATA = '0;
  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Sequential fall-through address; wraps naturally.
  function automatic logic [DATA_WIDTH-1:0] seq_pc(
    input logic [DATA_WIDTH-1:0] pc
  );
    return pc + DATA_WIDTH'(4);
  endfunction

endpackage

// File: rtl/branch_resolver.sv
// In-order branch queue: allocate, resolve out of order,
// retire in program order and flush on a mispredict.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int QUEUE_DEPTH = BQ_DEPTH,
  parameter int TAG_WIDTH   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  in_alloc_valid,
  input  logic [DATA_WIDTH-1:0] in_alloc_pc,
  input  logic                  in_alloc_pred_taken,
  output logic [TAG_WIDTH-1:0]  out_alloc_tag,
  output logic                  out_full,
  input  logic                  in_resolve_valid,
  input  logic [TAG_WIDTH-1:0]  in_resolve_tag,
  input  logic                  in_resolve_taken,
  input  logic [DATA_WIDTH-1:0] in_resolve_target,
  output logic                  out_forwarding_valid,
  output logic [DATA_WIDTH-1:0] out_forwarding_branch_pc,
  output logic                  out_forwarding_branch_taken,
  output logic [DATA_WIDTH-1:0] out_forwarding_correct_address,
  output logic                  out_misbranch
);

  localparam int CW = TAG_WIDTH + 1;

  logic [QUEUE_DEPTH-1:0] valid_q;
  logic [QUEUE_DEPTH-1:0] resolved_q;
  logic [QUEUE_DEPTH-1:0] pred_q;
  logic [QUEUE_DEPTH-1:0] taken_q;
  logic [DATA_WIDTH-1:0]  pc_q     [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0]  target_q [QUEUE_DEPTH];

  logic [TAG_WIDTH-1:0] head_q, head_d;
  logic [TAG_WIDTH-1:0] tail_q, tail_d;
  logic [CW-1:0]        count_q, count_d;

  logic                  fwd_valid_q;
  logic [DATA_WIDTH-1:0] fwd_pc_q;
  logic                  fwd_taken_q;
  logic [DATA_WIDTH-1:0] fwd_addr_q;
  logic                  mis_q;

  logic retire;
  logic flush;
  logic do_alloc;
  logic do_res;

  assign out_alloc_tag = tail_q;
  assign out_full      = (count_q == CW'(QUEUE_DEPTH));

  assign out_forwarding_valid           = fwd_valid_q;
  assign out_forwarding_branch_pc       = fwd_pc_q;
  assign out_forwarding_branch_taken    = fwd_taken_q;
  assign out_forwarding_correct_address = fwd_addr_q;
  assign out_misbranch                  = mis_q;

  // Decide this cycle's retire, flush, allocate and resolve.
  always_comb begin
    retire   = ena && valid_q[head_q] && resolved_q[head_q];
    flush    = retire && (taken_q[head_q] != pred_q[head_q]);
    do_alloc = ena && in_alloc_valid && !out_full && !flush;
    do_res   = ena && in_resolve_valid
             && valid_q[in_resolve_tag] && !flush;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (retire)   head_d = head_q + 1'b1;
      if (do_alloc) tail_d = tail_q + 1'b1;
      count_d = count_q + CW'(do_alloc) - CW'(retire);
    end
  end

  // Pointer, count and entry status bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      valid_q    <= '0;
      resolved_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (flush) begin
        valid_q    <= '0;
        resolved_q <= '0;
      end else begin
        if (do_res) resolved_q[in_resolve_tag] <= TRUE;
        if (retire) begin
          valid_q[head_q]    <= FALSE;
          resolved_q[head_q] <= FALSE;
        end
        if (do_alloc) begin
          valid_q[tail_q]    <= TRUE;
          resolved_q[tail_q] <= FALSE;
        end
      end
    end
  end

  // Entry payload; meaningful only while the entry is valid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (do_res) begin
        taken_q[in_resolve_tag]  <= in_resolve_taken;
        target_q[in_resolve_tag] <= in_resolve_target;
      end
      if (do_alloc) begin
        pc_q[tail_q]   <= in_alloc_pc;
        pred_q[tail_q] <= in_alloc_pred_taken;
      end
    end
  end

  // Registered retire report to the predictor.
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_valid_q <= FALSE;
      mis_q       <= FALSE;
      fwd_pc_q    <= ZERO_DATA;
      fwd_taken_q <= FALSE;
      fwd_addr_q  <= ZERO_DATA;
    end else begin
      fwd_valid_q <= retire;
      mis_q       <= flush;
      if (retire) begin
        fwd_pc_q    <= pc_q[head_q];
        fwd_taken_q <= taken_q[head_q];
        fwd_addr_q  <= taken_q[head_q] ? target_q[head_q]
                                       : seq_pc(pc_q[head_q]);
      end
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver.
// Reference model keeps pending branches in a program-order queue.
module tb_branch_resolver;
  import branch_resolver_pkg::*;

  localparam int QD = 4;

  logic        clk = 1'b0;
  logic        rst, ena;
  logic        in_alloc_valid, in_alloc_pred_taken;
  logic [31:0] in_alloc_pc;
  logic [1:0]  out_alloc_tag;
  logic        out_full;
  logic        in_resolve_valid, in_resolve_taken;
  logic [1:0]  in_resolve_tag;
  logic [31:0] in_resolve_target;
  logic        out_forwarding_valid, out_forwarding_branch_taken;
  logic [31:0] out_forwarding_branch_pc, out_forwarding_correct_address;
  logic        out_misbranch;

  branch_resolver dut (
    .clk(clk), .rst(rst), .ena(ena),
    .in_alloc_valid(in_alloc_valid),
    .in_alloc_pc(in_alloc_pc),
    .in_alloc_pred_taken(in_alloc_pred_taken),
    .out_alloc_tag(out_alloc_tag),
    .out_full(out_full),
    .in_resolve_valid(in_resolve_valid),
    .in_resolve_tag(in_resolve_tag),
    .in_resolve_taken(in_resolve_taken),
    .in_resolve_target(in_resolve_target),
    .out_forwarding_valid(out_forwarding_valid),
    .out_forwarding_branch_pc(out_forwarding_branch_pc),
    .out_forwarding_branch_taken(out_forwarding_branch_taken),
    .out_forwarding_correct_address(out_forwarding_correct_address),
    .out_misbranch(out_misbranch)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    bit          pred;
    int          tag;
    bit          resolved;
    bit          taken;
    logic [31:0] target;
  } br_t;

  typedef struct {
    logic [31:0] pc;
    bit          taken;
    logic [31:0] addr;
    bit          mis;
    int          cyc;
  } exp_t;

  br_t  mq[$];
  exp_t sb[$];
  int   ntag = 0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] ex);
    n_checks++;
    if (act !== ex) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, ex);
    end
  endtask

  // Behavioural model of one clock edge.
  task automatic model(input bit r, e, av, input logic [31:0] apc,
                       input bit ap, rv, input int rt, input bit rtk,
                       input logic [31:0] rtg);
    int   sz0;
    bit   fl;
    br_t  b;
    exp_t x;
    if (r) begin
      mq.delete();
      ntag = 0;
      return;
    end
    if (!e) return;
    sz0 = mq.size();
    fl  = 0;
    if (sz0 > 0 && mq[0].resolved) begin
      b = mq.pop_front();
      x.pc    = b.pc;
      x.taken = b.taken;
      x.addr  = b.taken ? b.target : b.pc + 32'd4;
      x.mis   = (b.taken != b.pred);
      x.cyc   = cyc + 1;
      sb.push_back(x);
      fl = x.mis;
    end
    if (fl) begin
      mq.delete();
      ntag = 0;
      return;
    end
    if (rv)
      foreach (mq[i])
        if (mq[i].tag == rt) begin
          mq[i].resolved = 1;
          mq[i].taken    = rtk;
          mq[i].target   = rtg;
        end
    if (av && sz0 < QD) begin
      b.pc = apc; b.pred = ap; b.tag = ntag;
      b.resolved = 0; b.taken = 0; b.target = '0;
      mq.push_back(b);
      ntag = (ntag + 1) % QD;
    end
  endtask

  task automatic step(input bit r, e, av, input logic [31:0] apc,
                      input bit ap, rv, input int rt, input bit rtk,
                      input logic [31:0] rtg);
    @(negedge clk);
    chk("out_full", {31'd0, out_full}, {31'd0, mq.size() == QD});
    chk("alloc_tag", {30'd0, out_alloc_tag}, 32'(ntag));
    rst = r; ena = e;
    in_alloc_valid = av; in_alloc_pc = apc; in_alloc_pred_taken = ap;
    in_resolve_valid = rv; in_resolve_tag = rt[1:0];
    in_resolve_taken = rtk; in_resolve_target = rtg;
    model(r, e, av, apc, ap, rv, rt, rtk, rtg);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic alloc(input logic [31:0] pc, input bit p);
    step(0, 1, 1, pc, p, 0, 0, 0, 0);
  endtask

  task automatic resolve(input int t, input bit tk,
                         input logic [31:0] tg);
    step(0, 1, 0, 0, 0, 1, t, tk, tg);
  endtask

  task automatic outs_zero(input string nm);
    @(negedge clk);
    chk({nm, "_valid"}, {31'd0, out_forwarding_valid}, 0);
    chk({nm, "_mis"}, {31'd0, out_misbranch}, 0);
    chk({nm, "_pc"}, out_forwarding_branch_pc, 0);
    chk({nm, "_taken"}, {31'd0, out_forwarding_branch_taken}, 0);
    chk({nm, "_addr"}, out_forwarding_correct_address, 0);
  endtask

  // Monitor: pop and compare on every retire pulse.
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (out_forwarding_valid) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_retire: pc %h at cyc %0d",
                 out_forwarding_branch_pc, cyc);
      end else begin
        x = sb.pop_front();
        if (out_forwarding_branch_pc !== x.pc ||
            out_forwarding_branch_taken !== x.taken ||
            out_forwarding_correct_address !== x.addr ||
            out_misbranch !== x.mis || cyc != x.cyc) begin
          n_err++;
          $display("FAIL retire: got pc %h tk %b addr %h mis %b cyc %0d expected pc %h tk %b addr %h mis %b cyc %0d",
                   out_forwarding_branch_pc, out_forwarding_branch_taken,
                   out_forwarding_correct_address, out_misbranch, cyc,
                   x.pc, x.taken, x.addr, x.mis, x.cyc);
        end
      end
    end else begin
      if (out_misbranch) begin
        n_checks++;
        n_err++;
        $display("FAIL misbranch_alone: got 1 expected 0 at cyc %0d", cyc);
      end
      if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        n_checks++;
        n_err++;
        x = sb.pop_front();
        $display("FAIL missing_retire: got none expected pc %h at cyc %0d",
                 x.pc, x.cyc);
      end
    end
  end

  initial begin
    int   unres[$];
    int   t;
    bit   av, ap, rv, tk, e, r;
    logic [31:0] pc, tg;
    rst = 1; ena = 1;
    in_alloc_valid = 0; in_alloc_pc = 0; in_alloc_pred_taken = 0;
    in_resolve_valid = 0; in_resolve_tag = 0;
    in_resolve_taken = 0; in_resolve_target = 0;
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    outs_zero("reset");
    idle(1);

    // Correctly predicted not-taken.
    alloc(32'h100, 0);
    resolve(0, 0, 32'h999);
    idle(3);

    // Mispredicted taken, resolved through its tag.
    alloc(32'h200, 0);
    resolve(1, 1, 32'h180);
    idle(3);

    // Out-of-order resolution, in-order retirement.
    alloc(32'h10, 0);
    alloc(32'h20, 0);
    alloc(32'h30, 0);
    resolve(2, 0, 0);
    resolve(1, 0, 0);
    resolve(0, 0, 0);
    idle(5);

    // Fill, overflow attempt, retire with blocked alloc, tag wrap.
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    alloc(32'h1000, 0);
    alloc(32'h1004, 1);
    alloc(32'h1008, 0);
    alloc(32'h100c, 1);
    alloc(32'h1010, 0);
    resolve(0, 0, 0);
    alloc(32'h1014, 0);
    idle(1);
    alloc(32'h1018, 1);
    idle(2);

    // Flush drops a same-cycle alloc and resolve.
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    alloc(32'h400, 0);
    alloc(32'h404, 0);
    resolve(0, 1, 32'h800);
    step(0, 1, 1, 32'h408, 1, 1, 1, 0, 0);
    idle(3);

    // Reset with pending entries and a retire due.
    alloc(32'h500, 0);
    alloc(32'h504, 0);
    alloc(32'h508, 0);
    resolve(0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    outs_zero("rst_pending");
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);

    // pc+4 wraps around the address space.
    alloc(32'hFFFF_FFFC, 0);
    resolve(0, 0, 0);
    idle(3);

    // Enable low holds state and suppresses retire.
    alloc(32'h600, 1);
    resolve(1, 1, 32'h700);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h604, 0, 0, 0, 0, 0);
    idle(3);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom % 250) == 0;
      e  = ($urandom % 8) != 0;
      av = $urandom % 2;
      pc = $urandom & 32'hFFFF_FFFC;
      if ($urandom % 16 == 0) pc = 32'hFFFF_FFF8 | ($urandom & 32'h4);
      ap = $urandom % 2;
      rv = ($urandom % 3) != 0;
      unres.delete();
      foreach (mq[i]) if (!mq[i].resolved) unres.push_back(i);
      if (unres.size() > 0 && ($urandom % 8) != 0) begin
        t  = unres[$urandom % unres.size()];
        tk = (($urandom % 5) == 0) ? !mq[t].pred : mq[t].pred;
        t  = mq[t].tag;
      end else begin
        t  = $urandom % QD;
        tk = $urandom % 2;
      end
      tg = $urandom & 32'hFFFF_FFFC;
      step(r, e, av, pc, ap, rv, t, tk, tg);
    end

    idle(12);
    @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
